// File: rtl/rst_button_ctrl.sv
// Front-panel reset-button controller: synchronises, debounces and times the
// button, issuing a short-press event or an active-low reset pulse after a long hold.
module rst_button_ctrl #(
  parameter int TICK_DIV    = 33000,
  parameter int DEBOUNCE_MS = 16,
  parameter int HOLD_MS     = 4000,
  parameter int PULSE_MS    = 100
) (
  input  logic       MCLKi,
  input  logic       HARD_nRESETi,
  input  logic       RST_BTN_N,
  input  logic       FM_PS_EN,
  output logic       ResetOut_ox,
  output logic       BtnDebounced_N,
  output logic       HoldActive,
  output logic       ShortPress,
  output logic [7:0] ResetCount
);

  localparam logic [15:0] TICK_LAST  = 16'(TICK_DIV - 1);
  localparam logic [15:0] DB_LIMIT   = 16'(DEBOUNCE_MS);
  localparam logic [15:0] HOLD_LIMIT = 16'(HOLD_MS);
  localparam logic [15:0] PULSE_LIM  = 16'(PULSE_MS);

  typedef enum logic [1:0] {IDLE, HELD, FIRE, WAIT_REL} state_t;

  state_t      state, state_d;
  logic        sync1, sync2;
  logic [15:0] pre_cnt;
  logic        tick;
  logic [15:0] db_cnt;
  logic [15:0] db_inc;
  logic [15:0] hold_cnt, hold_d, hold_inc;
  logic [15:0] pulse_cnt, pulse_d, pulse_inc;
  logic        short_d;
  logic        fire_d;

  always_ff @(posedge MCLKi or negedge HARD_nRESETi) begin
    if (!HARD_nRESETi) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= RST_BTN_N;
      sync2 <= sync1;
    end
  end

  assign tick = (pre_cnt == TICK_LAST);

  always_ff @(posedge MCLKi or negedge HARD_nRESETi) begin
    if (!HARD_nRESETi) begin
      pre_cnt <= 16'd0;
    end else if (tick) begin
      pre_cnt <= 16'd0;
    end else begin
      pre_cnt <= pre_cnt + 16'd1;
    end
  end

  // Any cycle where the synced level agrees with the accepted level restarts the count,
  // so only an uninterrupted disagreement lasting DEBOUNCE_MS ticks is accepted.
  assign db_inc = db_cnt + 16'd1;

  always_ff @(posedge MCLKi or negedge HARD_nRESETi) begin
    if (!HARD_nRESETi) begin
      db_cnt         <= 16'd0;
      BtnDebounced_N <= 1'b1;
    end else if (sync2 == BtnDebounced_N) begin
      db_cnt <= 16'd0;
    end else if (tick) begin
      if (db_inc == DB_LIMIT) begin
        BtnDebounced_N <= sync2;
        db_cnt         <= 16'd0;
      end else begin
        db_cnt <= db_inc;
      end
    end
  end

  assign hold_inc  = hold_cnt + 16'd1;
  assign pulse_inc = pulse_cnt + 16'd1;

  always_comb begin
    state_d = state;
    hold_d  = hold_cnt;
    pulse_d = pulse_cnt;
    short_d = 1'b0;
    fire_d  = 1'b0;
    if (!FM_PS_EN) begin
      state_d = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          hold_d = 16'd0;
          if (!BtnDebounced_N) state_d = HELD;
        end
        HELD: begin
          if (tick) hold_d = hold_inc;
          // Reaching the hold limit wins over a release seen in the same cycle.
          if (tick && (hold_inc == HOLD_LIMIT)) begin
            state_d = FIRE;
            pulse_d = 16'd0;
            fire_d  = 1'b1;
          end else if (BtnDebounced_N) begin
            short_d = 1'b1;
            state_d = IDLE;
          end
        end
        FIRE: begin
          if (tick) begin
            pulse_d = pulse_inc;
            if (pulse_inc == PULSE_LIM) state_d = WAIT_REL;
          end
        end
        WAIT_REL: begin
          if (BtnDebounced_N) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge MCLKi or negedge HARD_nRESETi) begin
    if (!HARD_nRESETi) begin
      state       <= IDLE;
      hold_cnt    <= 16'd0;
      pulse_cnt   <= 16'd0;
      ResetOut_ox <= 1'b1;
      HoldActive  <= 1'b0;
      ShortPress  <= 1'b0;
      ResetCount  <= 8'd0;
    end else begin
      state       <= state_d;
      hold_cnt    <= hold_d;
      pulse_cnt   <= pulse_d;
      ResetOut_ox <= (state_d != FIRE);
      HoldActive  <= (state_d == HELD);
      ShortPress  <= short_d;
      if (fire_d && (ResetCount != 8'hFF)) ResetCount <= ResetCount + 8'd1;
    end
  end

endmodule
